// File: rtl/sum_branch_ctrl.sv
// sum_branch_ctrl: decode-stage branch resolution sequencer for a 5-stage MIPS
// pipeline. Accepts one branch at a time, collects its two operands as their
// hazards clear, evaluates the condition from a registered 33-bit
// sign-extended sum or an equality compare, and emits a one-cycle
// resolve/redirect pulse. Holds the front end stalled while busy.
//
// Optional feature: define BR_STAT_EN to add the stat_taken, stat_nottaken
// and stat_timeout saturating counters and their output ports.
module sum_branch_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,  // 1..255 cycles in WAIT before abort
  parameter int unsigned CNT_W      = 16   // statistics counter width
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_op,
  input  logic [31:0]       br_target,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic              rs_ready,
  input  logic              rt_ready,
  input  logic              kill,
  output logic              stall,
  output logic              resolve_valid,
  output logic              taken,
  output logic [31:0]       redirect_pc,
  output logic              timeout
`ifdef BR_STAT_EN
  ,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_nottaken,
  output logic [CNT_W-1:0]  stat_timeout
`endif
);

  // Controller states.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_EVAL    = 2'd2;
  localparam logic [1:0] ST_RESOLVE = 2'd3;

  // Branch opcodes; 5..7 are reserved and never taken.
  localparam logic [2:0] OP_BEQ     = 3'd0;
  localparam logic [2:0] OP_BNE     = 3'd1;
  localparam logic [2:0] OP_BZSUM   = 3'd2;
  localparam logic [2:0] OP_BNZSUM  = 3'd3;
  localparam logic [2:0] OP_BLTZSUM = 3'd4;

  // Last legal value of the wait counter; reaching it with an operand still
  // missing aborts the branch.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [2:0]  op_q;
  logic [31:0] target_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic        rs_cap_q;
  logic        rt_cap_q;
  logic [7:0]  wait_cnt_q;
  logic [32:0] sum_q;
  logic        eq_q;

  logic        accept;
  logic        rs_have;
  logic        rt_have;
  logic        wait_expire;
  logic        cond;

  // Handshake and per-cycle operand availability (captured earlier or arriving now).
  always_comb begin
    br_ready    = (state_q == ST_IDLE) && !kill;
    accept      = br_valid && br_ready;
    rs_have     = rs_cap_q || rs_ready;
    rt_have     = rt_cap_q || rt_ready;
    wait_expire = (state_q == ST_WAIT) && !(rs_have && rt_have)
                  && (wait_cnt_q == LIMIT_M1);
  end

  // Next-state selection; kill overrides everything and returns to IDLE.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) state_d = (rs_ready && rt_ready) ? ST_EVAL : ST_WAIT;
        end
        ST_WAIT: begin
          if (rs_have && rt_have) state_d = ST_EVAL;
          else if (wait_expire)   state_d = ST_IDLE;
        end
        ST_EVAL:    state_d = ST_RESOLVE;
        ST_RESOLVE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is written with non-blocking assignments so that
    // every register samples the pre-edge values of the others.
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Wait counter: counts consecutive cycles spent in WAIT, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Branch latch and independent operand capture with per-operand flags.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the operand and target registers are reset too; they are few
    // flops and a known post-reset value keeps the datapath deterministic.
    if (!reset_n) begin
      op_q     <= '0;
      target_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rs_cap_q <= 1'b0;
      rt_cap_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= br_op;
        target_q <= br_target;
      end
      if (kill) begin
        rs_cap_q <= 1'b0;
        rt_cap_q <= 1'b0;
      end else if (accept) begin
        rs_cap_q <= rs_ready;
        rt_cap_q <= rt_ready;
        if (rs_ready) rs_q <= rs_data;
        if (rt_ready) rt_q <= rt_data;
      end else if ((state_q == ST_WAIT) && !wait_expire) begin
        if (!rs_cap_q && rs_ready) begin
          rs_q     <= rs_data;
          rs_cap_q <= 1'b1;
        end
        if (!rt_cap_q && rt_ready) begin
          rt_q     <= rt_data;
          rt_cap_q <= 1'b1;
        end
      end else begin
        rs_cap_q <= 1'b0;
        rt_cap_q <= 1'b0;
      end
    end
  end

  // EVAL: register the 33-bit sign-extended sum (cannot wrap) and the equality.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      eq_q  <= 1'b0;
    end else if (state_q == ST_EVAL) begin
      sum_q <= {rs_q[31], rs_q} + {rt_q[31], rt_q};
      eq_q  <= (rs_q == rt_q);
    end
  end

  // Branch condition from the registered evaluation results.
  always_comb begin
    cond = 1'b0;
    case (op_q)
      OP_BEQ:     cond = eq_q;
      OP_BNE:     cond = !eq_q;
      OP_BZSUM:   cond = (sum_q == 33'd0);
      OP_BNZSUM:  cond = (sum_q != 33'd0);
      OP_BLTZSUM: cond = sum_q[32];
      default:    cond = 1'b0;
    endcase
  end

  // Outputs: only RESOLVE drives the result, and kill gates it in the same cycle.
  always_comb begin
    stall         = (state_q != ST_IDLE);
    resolve_valid = (state_q == ST_RESOLVE) && !kill;
    taken         = resolve_valid && cond;
    redirect_pc   = resolve_valid ? target_q : 32'd0;
    timeout       = wait_expire && !kill;
  end

`ifdef BR_STAT_EN
  // Saturating statistics counters for resolved and timed-out branches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_taken    <= '0;
      stat_nottaken <= '0;
      stat_timeout  <= '0;
    end else begin
      if (resolve_valid && taken && (stat_taken != '1))
        stat_taken <= stat_taken + CNT_W'(1);
      if (resolve_valid && !taken && (stat_nottaken != '1))
        stat_nottaken <= stat_nottaken + CNT_W'(1);
      if (timeout && (stat_timeout != '1))
        stat_timeout <= stat_timeout + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sum_branch_ctrl.sv
// Self-checking bench for sum_branch_ctrl. Each branch is described by its
// operands, the cycle (relative to accept) at which each operand first becomes
// ready, and an optional kill cycle; the expected output timeline is derived
// from those with plain arithmetic and compared every cycle at the falling edge.
module tb_sum_branch_ctrl;

  localparam int WL = 4;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_target;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_ready;
  logic        rt_ready;
  logic        kill;
  logic        stall;
  logic        resolve_valid;
  logic        taken;
  logic [31:0] redirect_pc;
  logic        timeout;
`ifdef BR_STAT_EN
  logic [CW-1:0] stat_taken;
  logic [CW-1:0] stat_nottaken;
  logic [CW-1:0] stat_timeout;
`endif

  always #5 clk = ~clk;

  sum_branch_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_op         (br_op),
    .br_target     (br_target),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .rs_ready      (rs_ready),
    .rt_ready      (rt_ready),
    .kill          (kill),
    .stall         (stall),
    .resolve_valid (resolve_valid),
    .taken         (taken),
    .redirect_pc   (redirect_pc),
    .timeout       (timeout)
`ifdef BR_STAT_EN
    ,
    .stat_taken    (stat_taken),
    .stat_nottaken (stat_nottaken),
    .stat_timeout  (stat_timeout)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, set by the stimulus tasks.
  bit          chk_en = 1'b0;
  bit          e_stall, e_ready, e_res, e_taken, e_to;
  logic [31:0] e_pc;

  // What the DUT actually did during the latest branch.
  int          cur_j;
  int          seen_res_j;
  int          seen_to_j;
  logic        seen_taken;
  logic [31:0] seen_pc;

  // Expected statistics.
  int n_taken = 0;
  int n_not   = 0;
  int n_to    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference condition from plain signed arithmetic on 64-bit integers.
  function automatic bit model_taken(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return s == 0;
      3'd3:    return s != 0;
      3'd4:    return s < 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Single compare process: every cycle, at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, e_stall);
      check("br_ready", br_ready, e_ready);
      check("resolve_valid", resolve_valid, e_res);
      check("taken", taken, e_taken);
      check("redirect_pc", redirect_pc, e_pc);
      check("timeout", timeout, e_to);
      if (resolve_valid) begin
        seen_res_j = cur_j;
        seen_taken = taken;
        seen_pc    = redirect_pc;
      end
      if (timeout) seen_to_j = cur_j;
    end
  end

  // One cycle with the controller idle; br_valid only accompanies kill here.
  task automatic idle_cycle(input bit kill_v, input bit valid_v);
    kill      = kill_v;
    br_valid  = valid_v && kill_v;
    br_op     = 3'($urandom);
    br_target = $urandom;
    rs_ready  = 1'($urandom);
    rt_ready  = 1'($urandom);
    rs_data   = $urandom;
    rt_data   = $urandom;
    e_stall   = 1'b0;
    e_ready   = !kill_v;
    e_res     = 1'b0;
    e_taken   = 1'b0;
    e_pc      = 32'd0;
    e_to      = 1'b0;
    cur_j     = -1;
    @(posedge clk); #1;
  endtask

  // One branch: cycle 0 is the accept cycle. drs/drt give the first cycle each
  // operand is ready; kc (0 = none) gives the kill cycle.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] tgt,
                         input logic [31:0] rsv, input logic [31:0] rtv,
                         input int drs, input int drt, input int kc_in);
    int k, last, kc;
    bit to, exp_t;
    k     = (drs > drt) ? drs : drt;
    to    = (k > WL);
    last  = to ? WL : k + 2;
    kc    = (kc_in > last) ? 0 : kc_in;
    exp_t = model_taken(op, rsv, rtv);
    seen_res_j = -1;
    seen_to_j  = -1;
    for (int j = 0; j <= last; j++) begin
      cur_j = j;
      if (j == 0) begin
        br_valid  = 1'b1;
        br_op     = op;
        br_target = tgt;
      end else begin
        br_valid  = 1'($urandom);
        br_op     = 3'($urandom);
        br_target = $urandom;
      end
      rs_ready = (j == drs) ? 1'b1 : ((j < drs) ? 1'b0 : 1'($urandom));
      rt_ready = (j == drt) ? 1'b1 : ((j < drt) ? 1'b0 : 1'($urandom));
      rs_data  = (j == drs) ? rsv : $urandom;
      rt_data  = (j == drt) ? rtv : $urandom;
      kill     = (kc != 0) && (j == kc);
      e_stall  = (j != 0);
      e_ready  = (j == 0);
      e_res    = !kill && !to && (j == k + 2);
      e_taken  = e_res && exp_t;
      e_pc     = e_res ? tgt : 32'd0;
      e_to     = !kill && to && (j == WL);
      if (e_res && exp_t)  n_taken++;
      if (e_res && !exp_t) n_not++;
      if (e_to)            n_to++;
      @(posedge clk); #1;
      if (kill) break;
    end
    kill = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; br_valid = 1'b0; br_op = '0; br_target = '0;
    rs_data = '0; rt_data = '0; rs_ready = 1'b0; rt_ready = 1'b0; kill = 1'b0;
    cur_j = -1; seen_res_j = -1; seen_to_j = -1; seen_taken = 1'b0; seen_pc = '0;
    e_stall = 0; e_ready = 1; e_res = 0; e_taken = 0; e_pc = '0; e_to = 0;
    #1;
    check("reset_stall", stall, 0);
    check("reset_br_ready", br_ready, 1);
    check("reset_resolve", resolve_valid, 0);
    check("reset_taken", taken, 0);
    check("reset_pc", redirect_pc, 0);
    check("reset_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Pin the reference condition on the boundary cases.
    check("model_bzsum_min", model_taken(3'd2, 32'h8000_0000, 32'h8000_0000), 0);
    check("model_bltzsum_min", model_taken(3'd4, 32'h8000_0000, 32'h8000_0000), 1);
    check("model_bltzsum_max", model_taken(3'd4, 32'h7FFF_FFFF, 32'h1), 0);

    // bzsum 5 + -5, both ready at accept.
    run_txn(3'd2, 32'h0000_3010, 32'd5, 32'hFFFF_FFFB, 0, 0, 0);
    check("bzsum_res_cycle", seen_res_j, 2);
    check("bzsum_taken", seen_taken, 1);
    check("bzsum_pc", seen_pc, 32'h0000_3010);

    // Most-negative operands: the 33-bit sum is nonzero and negative.
    run_txn(3'd2, 32'h0000_4000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    check("bzsum_min_taken", seen_taken, 0);
    run_txn(3'd4, 32'h0000_4004, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    check("bltzsum_min_taken", seen_taken, 1);
    run_txn(3'd4, 32'h0000_4008, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0);
    check("bltzsum_max_taken", seen_taken, 0);

    // beq with rt arriving three cycles late.
    run_txn(3'd0, 32'h0000_5000, 32'd7, 32'd7, 0, 3, 0);
    check("beq_wait_res_cycle", seen_res_j, 5);
    check("beq_wait_taken", seen_taken, 1);

    // rt never ready: timeout after WL cycles, no resolve.
    run_txn(3'd1, 32'h0000_6000, 32'd1, 32'd2, 0, WL + 5, 0);
    check("timeout_cycle", seen_to_j, 4);
    check("timeout_no_resolve", seen_res_j, -1);
    idle_cycle(0, 0);

    // kill in EVAL, then a new branch accepted the very next cycle.
    run_txn(3'd0, 32'h0000_7000, 32'd9, 32'd9, 0, 0, 1);
    check("kill_eval_no_resolve", seen_res_j, -1);
    run_txn(3'd1, 32'h0000_7100, 32'd9, 32'd8, 0, 0, 0);
    check("after_kill_res_cycle", seen_res_j, 2);
    check("after_kill_taken", seen_taken, 1);

    // kill in RESOLVE suppresses the pulse; kill in IDLE blocks acceptance.
    run_txn(3'd0, 32'h0000_7200, 32'd3, 32'd3, 0, 0, 2);
    check("kill_resolve_no_resolve", seen_res_j, -1);
    idle_cycle(1, 1);
    idle_cycle(0, 0);

    // Randomized branches.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a, b;
      int sel, drs, drt, kc, gap;
      a   = pick_val();
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? a : (sel == 1) ? -a : (sel == 2) ? pick_val() : $urandom;
      drs = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, WL + 2);
      drt = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, WL + 2);
      kc  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, WL + 2) : 0;
      run_txn(3'($urandom_range(0, 7)), $urandom, a, b, drs, drt, kc);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef BR_STAT_EN
    check("stat_taken_rand", stat_taken, n_taken);
    check("stat_nottaken_rand", stat_nottaken, n_not);
    check("stat_timeout_rand", stat_timeout, n_to);
`endif

    // Asynchronous reset while waiting for an operand.
    chk_en   = 1'b0;
    br_valid = 1'b1; br_op = 3'd0; br_target = 32'h100;
    rs_ready = 1'b1; rs_data = 32'd1; rt_ready = 1'b0; kill = 1'b0;
    @(posedge clk); #1;
    br_valid = 1'b0; rs_ready = 1'b0;
    @(posedge clk); #1;
    check("wait_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check("rst_wait_stall", stall, 0);
    check("rst_wait_br_ready", br_ready, 1);
    check("rst_wait_resolve", resolve_valid, 0);
    check("rst_wait_timeout", timeout, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    n_taken = 0; n_not = 0; n_to = 0;
    repeat (WL + 2) idle_cycle(0, 0);

    // Three taken and two not-taken branches after reset.
    run_txn(3'd0, 32'h0000_8000, 32'd4, 32'd4, 0, 0, 0);
    run_txn(3'd3, 32'h0000_8004, 32'd4, 32'd4, 1, 0, 0);
    run_txn(3'd4, 32'h0000_8008, 32'hFFFF_FFF0, 32'd1, 0, 2, 0);
    run_txn(3'd1, 32'h0000_800C, 32'd4, 32'd4, 0, 0, 0);
    run_txn(3'd5, 32'h0000_8010, 32'd4, 32'd5, 0, 0, 0);
    check("post_reset_last_res", seen_res_j, 2);
    check("reserved_not_taken", seen_taken, 0);
`ifdef BR_STAT_EN
    check("stat_taken_3", stat_taken, 3);
    check("stat_nottaken_2", stat_nottaken, 2);
    check("stat_timeout_0", stat_timeout, 0);
`endif
    idle_cycle(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
